// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 UART serialiser.
//   clk100       system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   wr_en/wr_data enqueue one byte per cycle; dropped when full
//   clr_overflow clears the sticky overflow flag (a same-cycle drop wins)
//   fifo_full/fifo_empty/fifo_count  occupancy, excluding the byte in flight
//   overflow     sticky flag, set when a write was dropped
//   tx_busy      FSM not idle
//   uart_tx      registered serial line, idle high, LSB first
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk100,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         clr_overflow,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         tx_busy,
  output logic                         uart_tx
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             push, pop, bit_end;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = wr_en && !fifo_full;
  assign bit_end    = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tx_busy    = (state_q != IDLE);

  // storage needs no reset; contents are dead once the pointers are cleared
  always_ff @(posedge clk100)
    if (push) mem[wr_ptr] <= wr_data;

  // pointers are exactly PW bits wide, so they wrap modulo the depth for free
  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      // full is judged before the edge, so a same-cycle pop does not rescue the write
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (clr_overflow)  overflow <= 1'b0;
    end

  always_ff @(posedge clk100 or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_tx   <= tx_d;
    end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE:
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      START:
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end else bit_cnt_d = bit_cnt_q + CNT_W'(1);
      DATA:
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else bit_cnt_d = bit_cnt_q + CNT_W'(1);
      STOP:
        if (bit_end) begin
          bit_cnt_d = '0;
          // chain straight into the next start bit so frames abut
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = mem[rd_ptr];
            bit_idx_d = '0;
            state_d   = START;
          end else state_d = IDLE;
        end else bit_cnt_d = bit_cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
    // line level is derived from the next state so uart_tx moves with the state register
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end
endmodule
